// File: rtl/wb_burst_master_if.sv
// Wishbone bus bundle between wb_burst_master and the SDRAM controller slave port.
// Signal names keep the slave-side (sdrc) naming: *_i are driven by the master,
// *_o are driven by the slave.
//   wb_cyc_i / wb_stb_i / wb_we_i : cycle, strobe, write enable
//   wb_addr_i [AW]                : beat byte address
//   wb_dat_i  [DW]                : write data
//   wb_sel_i  [DW/8]              : byte enables
//   wb_cti_i  [3]                 : cycle type (010 incrementing, 111 last)
//   wb_ack_o                      : slave acknowledge
//   wb_dat_o  [DW]                : slave read data
interface wb_burst_master_if #(
  parameter int unsigned AW = 26,
  parameter int unsigned DW = 32
);
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [AW-1:0] wb_addr_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW/8-1:0] wb_sel_i;
  logic [2:0]    wb_cti_i;
  logic          wb_ack_o;
  logic [DW-1:0] wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone burst master feeding the SDRAM controller's wb_* slave port.
// Commands (write/read, start address, beat count, data seed) are queued in a
// FIFO and issued as incremental bursts. Beat i carries / expects cmd_seed + i.
// A burst whose slave stops acking for ACK_TIMEOUT cycles is aborted.
// Optional feature macro: READ_CHECK_EN -- compare read data with seed + i and
// count mismatches in err_cnt (tied to 0 when undefined).
// Ports:
//   sys_clk, RESET            clock, synchronous active-high reset
//   sdr_init_done             gates the start of a new burst
//   cmd_valid/cmd_ready       command push handshake (cmd_ready = FIFO not full)
//   cmd_we/addr/bl/seed       command fields (bl = 0 treated as 1)
//   wb                        Wishbone master modport
//   rd_valid/rd_data          registered read beat, one-cycle pulse
//   busy                      FSM active or FIFO non-empty
//   done_pulse                one cycle at normal burst completion
//   timeout_err               sticky abort flag
//   err_cnt                   saturating read-mismatch count
module wb_burst_master #(
  parameter int unsigned AW          = 26,
  parameter int unsigned DW          = 32,
  parameter int unsigned BLW         = 8,
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic            sys_clk,
  input  logic            RESET,
  input  logic            sdr_init_done,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [BLW-1:0]  cmd_bl,
  input  logic [DW-1:0]   cmd_seed,
  wb_burst_master_if.master wb,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            busy,
  output logic            done_pulse,
  output logic            timeout_err,
  output logic [15:0]     err_cnt
);
  localparam int unsigned PW = $clog2(CMD_DEPTH);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {IDLE, XFER, DONE, ABORT} state_t;

  typedef struct packed {
    logic           we;
    logic [AW-1:0]  addr;
    logic [BLW-1:0] bl;
    logic [DW-1:0]  seed;
  } cmd_t;

  state_t state, state_nx;

  // Command FIFO
  cmd_t        fifo_mem [CMD_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, push, pop;
  cmd_t        head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr[PW-1:0]];

  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= '{we: cmd_we, addr: cmd_addr, bl: cmd_bl, seed: cmd_seed};
  end

  always_ff @(posedge sys_clk) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Burst datapath registers (all Wishbone outputs come straight from these)
  logic           cyc_q, stb_q, we_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  dat_q;
  logic [SW-1:0]  sel_q;
  logic [2:0]     cti_q;
  logic [BLW-1:0] beats_left;
  logic [TW-1:0]  tmo_cnt;
  logic           start_ok_q;
  logic           ack_ok, last_beat;

  assign ack_ok    = stb_q && wb.wb_ack_o;
  assign last_beat = (beats_left == BLW'(1));

  // Start qualifier is registered so the FIFO head has settled for a cycle
  // before it is popped; this sets the push-to-cyc latency at two edges.
  always_ff @(posedge sys_clk) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok_q && !fifo_empty && sdr_init_done) begin
          state_nx = XFER;
          pop      = 1'b1;
        end
      end
      XFER: begin
        // An ack coinciding with the terminal count wins over the abort.
        if (ack_ok) begin
          if (last_beat) state_nx = DONE;
        end else if (tmo_cnt == TW'(ACK_TIMEOUT)) begin
          state_nx = ABORT;
        end
      end
      DONE:    state_nx = IDLE;
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (RESET) begin
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      cti_q       <= '0;
      beats_left  <= '0;
      tmo_cnt     <= '0;
      start_ok_q  <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      start_ok_q <= !fifo_empty && sdr_init_done;
      cyc_q      <= (state_nx == XFER);
      stb_q      <= (state_nx == XFER);
      done_pulse <= (state_nx == DONE);
      rd_valid   <= 1'b0;
      if (state_nx == ABORT) timeout_err <= 1'b1;

      if (pop) begin
        we_q       <= head.we;
        addr_q     <= head.addr;
        dat_q      <= head.seed;
        sel_q      <= '1;
        beats_left <= (head.bl == '0) ? BLW'(1) : head.bl;
        cti_q      <= (head.bl <= BLW'(1)) ? 3'b111 : 3'b010;
        tmo_cnt    <= TW'(1);
      end else if (state == XFER) begin
        if (ack_ok) begin
          tmo_cnt <= TW'(1);
          if (!we_q) begin
            rd_valid <= 1'b1;
            rd_data  <= wb.wb_dat_o;
          end
          if (!last_beat) begin
            addr_q     <= addr_q + AW'(SW);
            dat_q      <= dat_q + 1'b1;
            beats_left <= beats_left - 1'b1;
            cti_q      <= (beats_left == BLW'(2)) ? 3'b111 : 3'b010;
          end
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end

      if (state_nx != XFER) begin
        we_q  <= 1'b0;
        sel_q <= '0;
        cti_q <= '0;
      end
    end
  end

`ifdef READ_CHECK_EN
  logic [15:0] err_q;

  always_ff @(posedge sys_clk) begin
    if (RESET) begin
      err_q <= '0;
    end else if (state == XFER && ack_ok && !we_q && wb.wb_dat_o != dat_q && err_q != 16'hFFFF) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

  assign busy         = (state != IDLE) || !fifo_empty;
  assign wb.wb_cyc_i  = cyc_q;
  assign wb.wb_stb_i  = stb_q;
  assign wb.wb_we_i   = we_q;
  assign wb.wb_addr_i = addr_q;
  assign wb.wb_dat_i  = dat_q;
  assign wb.wb_sel_i  = sel_q;
  assign wb.wb_cti_i  = cti_q;
endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;
  localparam int unsigned AW = 26, DW = 32, BLW = 8, CMD_DEPTH = 4, ACK_TIMEOUT = 64;

  logic           sys_clk = 1'b0;
  logic           RESET, sdr_init_done, cmd_valid, cmd_we;
  logic           cmd_ready, rd_valid, busy, done_pulse, timeout_err;
  logic [AW-1:0]  cmd_addr;
  logic [BLW-1:0] cmd_bl;
  logic [DW-1:0]  cmd_seed, rd_data;
  logic [15:0]    err_cnt;

  wb_burst_master_if #(.AW(AW), .DW(DW)) wb ();

  wb_burst_master #(
    .AW(AW), .DW(DW), .BLW(BLW), .CMD_DEPTH(CMD_DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .RESET(RESET), .sdr_init_done(sdr_init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_bl(cmd_bl), .cmd_seed(cmd_seed),
    .wb(wb),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .done_pulse(done_pulse), .timeout_err(timeout_err), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    cti;
  } beat_t;

  beat_t         beat_q[$];     // expected Wishbone beats, in order
  logic [DW-1:0] rd_ovr_q[$];   // slave read data overriding the expected value
  logic [DW-1:0] rd_exp_q[$];   // expected rd_data values
  int unsigned   n_cmp = 0, n_bad = 0;
  int unsigned   n_done = 0, n_rdv = 0, n_beats = 0;
  logic          ack_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic exp_beat(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] c);
    beat_t b;
    b.we = we; b.addr = a; b.data = d; b.cti = c;
    beat_q.push_back(b);
  endtask

  task automatic exp_cmd(input logic we, input logic [AW-1:0] a, input int n, input logic [DW-1:0] seed);
    for (int i = 0; i < n; i++)
      exp_beat(we, a + AW'(i * 4), seed + DW'(i), (i == n - 1) ? 3'b111 : 3'b010);
  endtask

  task automatic push_cmd(input logic we, input logic [AW-1:0] a, input logic [BLW-1:0] bl,
                          input logic [DW-1:0] seed, input int max_wait, output bit ok);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_bl = bl; cmd_seed = seed;
    ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int c = 0;
    while (busy && c < limit) begin tick(); c++; end
    check(name, 64'(busy), 64'(0));
  endtask

  // Slave model + monitor: acks on request, checks each presented beat and
  // every rd_valid against the scoreboard queues.
  always @(negedge sys_clk) begin : mon
    beat_t         e;
    logic [DW-1:0] d;
    if (rd_valid) begin
      n_rdv++;
      if (rd_exp_q.size() == 0) flag("rd_unexpected");
      else check("rd_data", 64'(rd_data), 64'(rd_exp_q.pop_front()));
    end
    if (done_pulse) n_done++;
    wb.wb_ack_o = 1'b0;
    if (ack_en && wb.wb_cyc_i && wb.wb_stb_i) begin
      wb.wb_ack_o = 1'b1;
      n_beats++;
      if (beat_q.size() == 0) flag("beat_unexpected");
      else begin
        e = beat_q.pop_front();
        check("beat_we", 64'(wb.wb_we_i), 64'(e.we));
        check("beat_addr", 64'(wb.wb_addr_i), 64'(e.addr));
        check("beat_cti", 64'(wb.wb_cti_i), 64'(e.cti));
        check("beat_sel", 64'(wb.wb_sel_i), 64'h0F);
        if (e.we) check("beat_wdata", 64'(wb.wb_dat_i), 64'(e.data));
        else begin
          d = (rd_ovr_q.size() != 0) ? rd_ovr_q.pop_front() : e.data;
          wb.wb_dat_o = d;
          rd_exp_q.push_back(d);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c, d0, b0, acc;
    logic seen;
    RESET = 1'b1; sdr_init_done = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_addr = '0; cmd_bl = '0; cmd_seed = '0;
    repeat (3) tick();
    RESET = 1'b0;

    // Reset state
    check("rst_cyc", 64'(wb.wb_cyc_i), 64'(0));
    check("rst_stb", 64'(wb.wb_stb_i), 64'(0));
    check("rst_sel", 64'(wb.wb_sel_i), 64'(0));
    check("rst_cti", 64'(wb.wb_cti_i), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_done", 64'(done_pulse), 64'(0));
    check("rst_timeout", 64'(timeout_err), 64'(0));
    check("rst_err_cnt", 64'(err_cnt), 64'(0));

    // T1: init gate
    ack_en = 1'b1;
    exp_beat(1'b1, 26'h40, 32'h11, 3'b111);
    push_cmd(1'b1, 26'h40, 8'd1, 32'h11, 4, ok);
    check("t1_push", 64'(ok), 64'(1));
    seen = 1'b0;
    repeat (20) begin if (wb.wb_cyc_i) seen = 1'b1; tick(); end
    check("t1_no_cyc_gated", 64'(seen), 64'(0));
    sdr_init_done = 1'b1;
    c = 0;
    while (!wb.wb_cyc_i && c < 10) begin tick(); c++; end
    check("t1_cyc_within_2", 64'(c >= 1 && c <= 2), 64'(1));
    wait_idle("t1_idle", 50);

    // T2: write burst, latency, done pulse, address wrap
    exp_beat(1'b1, 26'h100, 32'hA0, 3'b010);
    exp_beat(1'b1, 26'h104, 32'hA1, 3'b010);
    exp_beat(1'b1, 26'h108, 32'hA2, 3'b010);
    exp_beat(1'b1, 26'h10C, 32'hA3, 3'b111);
    d0 = n_done;
    push_cmd(1'b1, 26'h100, 8'd4, 32'hA0, 4, ok);
    c = 0;
    while (!wb.wb_cyc_i && c < 10) begin tick(); c++; end
    check("t2_latency", 64'(c), 64'(2));
    wait_idle("t2_idle", 50);
    check("t2_done_count", 64'(n_done - d0), 64'(1));
    exp_beat(1'b1, 26'h3FFFFFC, 32'h55, 3'b010);
    exp_beat(1'b1, 26'h0000000, 32'h56, 3'b111);
    push_cmd(1'b1, 26'h3FFFFFC, 8'd2, 32'h55, 4, ok);
    wait_idle("t2w_idle", 50);
    check("t2w_done_count", 64'(n_done - d0), 64'(2));

    // T3: read burst with one corrupted beat
    rd_ovr_q.push_back(32'hA0); rd_ovr_q.push_back(32'hA1);
    rd_ovr_q.push_back(32'hFF); rd_ovr_q.push_back(32'hA3);
    exp_cmd(1'b0, 26'h100, 4, 32'hA0);
    b0 = n_rdv;
    push_cmd(1'b0, 26'h100, 8'd4, 32'hA0, 4, ok);
    wait_idle("t3_idle", 50);
    check("t3_rd_pulses", 64'(n_rdv - b0), 64'(4));
`ifdef READ_CHECK_EN
    check("t3_err_cnt", 64'(err_cnt), 64'(1));
`else
    check("t3_err_cnt", 64'(err_cnt), 64'(0));
`endif

    // T4: backpressure, 6 pushes against a stalled slave
    ack_en = 1'b0;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      exp_cmd(k[0] == 1'b0, 26'h1000 + 26'(k * 'h40), 2, 32'(k * 'h10 + 5));
      push_cmd(k[0] == 1'b0, 26'h1000 + 26'(k * 'h40), 8'd2, 32'(k * 'h10 + 5), 2, ok);
      if (ok) acc++;
    end
    check("t4_accepted", 64'(acc), 64'(5));
    push_cmd(1'b1, 26'h2000, 8'd1, 32'h99, 4, ok);
    check("t4_sixth_rejected", 64'(ok), 64'(0));
    check("t4_cmd_ready_low", 64'(cmd_ready), 64'(0));
    d0 = n_done;
    ack_en = 1'b1;
    wait_idle("t4_idle", 200);
    check("t4_done_count", 64'(n_done - d0), 64'(5));

    // T5: ack timeout, then the queued command runs normally
    ack_en = 1'b0;
    d0 = n_done;
    push_cmd(1'b0, 26'h2000, 8'd2, 32'h77, 4, ok);
    exp_cmd(1'b1, 26'h3000, 3, 32'h30);
    push_cmd(1'b1, 26'h3000, 8'd3, 32'h30, 4, ok);
    c = 0;
    while (!wb.wb_stb_i && c < 10) begin tick(); c++; end
    c = 0;
    while (wb.wb_stb_i && c < 200) begin c++; tick(); end
    check("t5_stb_cycles", 64'(c), 64'(ACK_TIMEOUT));
    check("t5_cyc_dropped", 64'(wb.wb_cyc_i), 64'(0));
    check("t5_timeout_err", 64'(timeout_err), 64'(1));
    check("t5_no_done", 64'(n_done - d0), 64'(0));
    ack_en = 1'b1;
    wait_idle("t5_idle", 100);
    check("t5_next_done", 64'(n_done - d0), 64'(1));
    check("t5_beats_drained", 64'(beat_q.size()), 64'(0));

    // T6: reset mid-burst
    exp_cmd(1'b1, 26'h200, 8, 32'hC0);
    push_cmd(1'b1, 26'h200, 8'd8, 32'hC0, 4, ok);
    b0 = n_beats;
    c = 0;
    while (n_beats - b0 < 2 && c < 20) begin tick(); c++; end
    check("t6_reached_beat2", 64'(n_beats - b0 >= 2), 64'(1));
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    beat_q.delete();
    rd_exp_q.delete();
    d0 = n_done;
    check("t6_cyc", 64'(wb.wb_cyc_i), 64'(0));
    check("t6_stb", 64'(wb.wb_stb_i), 64'(0));
    check("t6_cmd_ready", 64'(cmd_ready), 64'(1));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_timeout_err", 64'(timeout_err), 64'(0));
    check("t6_err_cnt", 64'(err_cnt), 64'(0));
    seen = 1'b0;
    repeat (5) begin if (wb.wb_cyc_i) seen = 1'b1; tick(); end
    check("t6_no_restart", 64'(seen), 64'(0));
    check("t6_no_done", 64'(n_done - d0), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
